// File: rtl/stepper_sequencer_if.sv
// rtl/stepper_sequencer_if.sv - command, step-pulse and coil-drive bundle for the stepper sequencer
// master drives the move command and step pulses; slave is the sequencer.
interface stepper_sequencer_if #(
   parameter int CNT_W = 16,
   parameter int POS_W = 16
);
   logic             step_in;
   logic             dir;
   logic             half_step;
   logic             hold;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] steps_req;
   logic [3:0]       coils;
   logic             busy;
   logic             done;
   logic [POS_W-1:0] position;

   modport master (
      output step_in, dir, half_step, hold, start, stop, steps_req,
      input  coils, busy, done, position
   );

   modport slave (
      input  step_in, dir, half_step, hold, start, stop, steps_req,
      output coils, busy, done, position
   );
endinterface

// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - step-edge driven coil phase sequencer with counted moves
// Advances an 8-entry coil phase table per step_in rising edge and tracks signed half-step position.
module stepper_sequencer #(
   parameter int CNT_W = 16,
   parameter int POS_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   stepper_sequencer_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_step_q;
   logic [2:0]       r_index;
   logic [CNT_W-1:0] r_remaining;
   logic [POS_W-1:0] r_position;
   logic             r_busy;
   logic             r_done;

   logic             w_step_edge;
   logic [1:0]       w_mag;
   logic [2:0]       w_index_next;
   logic [POS_W-1:0] w_pos_next;
   logic [3:0]       w_phase;

   assign w_step_edge = bus.step_in & ~r_step_q;

   // Full-step from an even index is a one-notch alignment step onto the two-coil phases.
   assign w_mag = (bus.half_step | ~r_index[0]) ? 2'd1 : 2'd2;

   assign w_index_next = bus.dir ? (r_index + {1'b0, w_mag})
                                 : (r_index - {1'b0, w_mag});
   assign w_pos_next   = bus.dir ? (r_position + {{(POS_W-2){1'b0}}, w_mag})
                                 : (r_position - {{(POS_W-2){1'b0}}, w_mag});

   always_comb begin
      w_phase = 4'b0000;
      case (r_index)
         3'd0: w_phase = 4'b1000;
         3'd1: w_phase = 4'b1100;
         3'd2: w_phase = 4'b0100;
         3'd3: w_phase = 4'b0110;
         3'd4: w_phase = 4'b0010;
         3'd5: w_phase = 4'b0011;
         3'd6: w_phase = 4'b0001;
         3'd7: w_phase = 4'b1001;
         default: w_phase = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_step_q    <= 1'b0;
         r_index     <= 3'd0;
         r_remaining <= '0;
         r_position  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_step_q <= bus.step_in;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start & ~bus.stop) begin
                  if (bus.steps_req != '0) begin
                     r_state     <= RUN;
                     r_busy      <= 1'b1;
                     r_remaining <= bus.steps_req;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.stop) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_remaining <= '0;
               end else if (w_step_edge) begin
                  r_index     <= w_index_next;
                  r_position  <= w_pos_next;
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.coils    = (r_busy | bus.hold) ? w_phase : 4'b0000;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.position = r_position;

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - vector-table and scoreboard bench for stepper_sequencer
// Each record holds one cycle of inputs and the outputs expected just after that clock edge.
module tb_stepper_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stepper_sequencer_if #(.CNT_W(16), .POS_W(16)) bus ();

   stepper_sequencer #(.CNT_W(16), .POS_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic        stop;
      logic        step_in;
      logic        dir;
      logic        half_step;
      logic        hold;
      logic [15:0] steps_req;
      logic [3:0]  exp_coils;
      logic        exp_busy;
      logic        exp_done;
      logic [15:0] exp_pos;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   vec_no   = 0;

   function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic si,
                               input logic d, input logic h, input logic hd, input logic [15:0] n,
                               input logic [3:0] c, input logic b, input logic dn, input logic [15:0] p);
      vec_t v;
      v.rst = r; v.start = st; v.stop = sp; v.step_in = si;
      v.dir = d; v.half_step = h; v.hold = hd; v.steps_req = n;
      v.exp_coils = c; v.exp_busy = b; v.exp_done = dn; v.exp_pos = p;
      return v;
   endfunction

   task automatic add(input logic r, input logic st, input logic sp, input logic si,
                      input logic d, input logic h, input logic hd, input logic [15:0] n,
                      input logic [3:0] c, input logic b, input logic dn, input logic [15:0] p);
      vecs.push_back(mk(r, st, sp, si, d, h, hd, n, c, b, dn, p));
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", vec_no, name, act, req);
      end
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst           = v.rst;
      bus.start     = v.start;
      bus.stop      = v.stop;
      bus.step_in   = v.step_in;
      bus.dir       = v.dir;
      bus.half_step = v.half_step;
      bus.hold      = v.hold;
      bus.steps_req = v.steps_req;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("coils",    {12'd0, bus.coils}, {12'd0, e.exp_coils});
      check("busy",     {15'd0, bus.busy},  {15'd0, e.exp_busy});
      check("done",     {15'd0, bus.done},  {15'd0, e.exp_done});
      check("position", bus.position,       e.exp_pos);
      vec_no++;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.step_in = 1'b0;
      bus.dir = 1'b1; bus.half_step = 1'b1; bus.hold = 1'b0; bus.steps_req = 16'd0;

      //  rst st sp si d  h  hd  req      coils    b  dn  pos
      // Half-step forward, 3 steps, hold on
      add(1, 0, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000);
      add(1, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 1, 1, 16'd3, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0110, 0, 1, 16'h0003);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0110, 0, 0, 16'h0003);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0110, 0, 0, 16'h0003);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0110, 0, 0, 16'h0003);
      // Reverse wrap from index 0
      add(1, 0, 0, 0, 0, 1, 1, 16'd0, 4'b1000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 0, 1, 1, 16'd2, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 1, 0, 1, 1, 16'd0, 4'b1001, 1, 0, 16'hFFFF);
      add(0, 0, 0, 0, 0, 1, 1, 16'd0, 4'b1001, 1, 0, 16'hFFFF);
      add(0, 0, 0, 1, 0, 1, 1, 16'd0, 4'b0001, 0, 1, 16'hFFFE);
      add(0, 0, 0, 0, 0, 1, 0, 16'd0, 4'b0000, 0, 0, 16'hFFFE);
      // Full-step with alignment step from even index
      add(1, 0, 0, 0, 1, 0, 1, 16'd0, 4'b1000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 0, 1, 16'd3, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 1, 1, 0, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 0, 1, 0, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 1, 1, 0, 1, 16'd0, 4'b0110, 1, 0, 16'h0003);
      add(0, 0, 0, 0, 1, 0, 1, 16'd0, 4'b0110, 1, 0, 16'h0003);
      add(0, 0, 0, 1, 1, 0, 1, 16'd0, 4'b0011, 0, 1, 16'h0005);
      add(0, 0, 0, 0, 1, 0, 1, 16'd0, 4'b0011, 0, 0, 16'h0005);
      // Stop colliding with a step edge at remaining 4, then restart
      add(1, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 1, 1, 16'd6, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 1, 1, 1, 1, 1, 16'd0, 4'b0100, 0, 0, 16'h0002);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0100, 0, 0, 16'h0002);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0100, 0, 0, 16'h0002);
      add(0, 1, 0, 0, 1, 1, 1, 16'd1, 4'b0100, 1, 0, 16'h0002);
      add(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0110, 0, 1, 16'h0003);
      add(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0110, 0, 0, 16'h0003);
      // Zero-length move, then start while busy must not reload remaining
      add(1, 0, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 1, 16'h0000);
      add(0, 0, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 1, 0, 16'd2, 4'b1000, 1, 0, 16'h0000);
      add(0, 1, 0, 0, 1, 1, 0, 16'd5, 4'b1000, 1, 0, 16'h0000);
      add(0, 0, 0, 1, 1, 1, 0, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 0, 1, 1, 0, 16'd0, 4'b1100, 1, 0, 16'h0001);
      add(0, 0, 0, 1, 1, 1, 0, 16'd0, 4'b0000, 0, 1, 16'h0002);
      add(0, 0, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0002);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Long step_in high gives one step; reset mid-move clears everything with no done
      apply(mk(1, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1000, 0, 0, 16'h0000));
      apply(mk(0, 1, 0, 0, 1, 1, 1, 16'd3, 4'b1000, 1, 0, 16'h0000));
      for (int i = 0; i < 50; i++)
         apply(mk(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001));
      apply(mk(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b1100, 1, 0, 16'h0001));
      apply(mk(0, 0, 0, 1, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002));
      apply(mk(0, 0, 0, 0, 1, 1, 1, 16'd0, 4'b0100, 1, 0, 16'h0002));
      apply(mk(1, 0, 0, 1, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000));
      apply(mk(0, 0, 0, 1, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000));
      apply(mk(0, 0, 0, 0, 1, 1, 0, 16'd0, 4'b0000, 0, 0, 16'h0000));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
